// File: rtl/ram_bank_if.sv
// rtl/ram_bank_if.sv - access/clear port bundle for ram_bank
interface ram_bank_if #(
  parameter int DATA_W = 3,
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] wr_data;
  logic              clr_req;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              clr_done;
  logic              wr_drop;

  modport master (
    output addr, we, wr_data, clr_req,
    input  rd_data, busy, clr_done, wr_drop
  );

  modport slave (
    input  addr, we, wr_data, clr_req,
    output rd_data, busy, clr_done, wr_drop
  );
endinterface

// File: rtl/ram_bank.sv
// rtl/ram_bank.sv - single-port RAM bank with full-array clear sequencer
module ram_bank #(
  parameter int DATA_W = 3,
  parameter int ADDR_W = 12,
  parameter int REG_RD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  ram_bank_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              drop_q;

  logic busy;
  logic last_clr;
  logic wr_ok;
  logic wr_rej;

  // Access arbitration: the clear sequencer and a pending clear request both outrank writes.
  always_comb begin
    busy     = (state == ST_CLEAR);
    last_clr = busy && (clr_ptr == {ADDR_W{1'b1}});
    wr_ok    = !busy && bus.we && !bus.clr_req;
    wr_rej   = bus.we && (busy || bus.clr_req);
  end

  // Clear sequencer: walks clr_ptr across the whole array, then returns to IDLE; clr_req in CLEAR is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= wr_rej;
      if (busy) begin
        clr_ptr <= clr_ptr + ADDR_W'(1);
        if (last_clr) begin
          state <= ST_IDLE;
        end
      end else if (bus.clr_req) begin
        state   <= ST_CLEAR;
        clr_ptr <= '0;
      end
    end
  end

  // Array write port: reset leaves contents alone; zeroing is done only by the clear walk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n) begin
      if (busy) begin
        mem[clr_ptr] <= '0;
      end else if (wr_ok) begin
        mem[bus.addr] <= bus.wr_data;
      end
    end
  end

  generate
    if (REG_RD != 0) begin : g_reg_rd
      logic [DATA_W-1:0] rd_q;

      // Registered read, write-first so an accepted write shows up on the same-address read.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_q <= '0;
        end else if (busy) begin
          rd_q <= '0;
        end else if (wr_ok) begin
          rd_q <= bus.wr_data;
        end else begin
          rd_q <= mem[bus.addr];
        end
      end

      assign bus.rd_data = rd_q;
    end else begin : g_comb_rd
      assign bus.rd_data = busy ? '0 : mem[bus.addr];
    end
  endgenerate

  assign bus.busy     = busy;
  assign bus.clr_done = last_clr;
  assign bus.wr_drop  = drop_q;

endmodule

// File: tb/tb_ram_bank.sv
// tb/tb_ram_bank.sv - randomized model-checked bench for ram_bank in both read modes
module tb_ram_bank;

  localparam int DW    = 3;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ram_bank_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  ram_bank_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  ram_bank #(.DATA_W(DW), .ADDR_W(AW), .REG_RD(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  ram_bank #(.DATA_W(DW), .ADDR_W(AW), .REG_RD(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: array contents, number of clear cycles still to run, pending pulses.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_left;
  logic          m_drop;
  logic [DW-1:0] m_rd1;

  logic [AW-1:0] cur_a;
  logic          cur_w;
  logic [DW-1:0] cur_d;
  logic          cur_c;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d, input logic c);
    cur_a = a; cur_w = w; cur_d = d; cur_c = c;
    bus0.addr = a; bus0.we = w; bus0.wr_data = d; bus0.clr_req = c;
    bus1.addr = a; bus1.we = w; bus1.wr_data = d; bus1.clr_req = c;
  endtask

  task automatic check_outputs();
    logic b;
    b = (m_left > 0);
    chk("busy_comb",     32'(bus0.busy),     32'(b));
    chk("busy_reg",      32'(bus1.busy),     32'(b));
    chk("clr_done_comb", 32'(bus0.clr_done), 32'(m_left == 1));
    chk("clr_done_reg",  32'(bus1.clr_done), 32'(m_left == 1));
    chk("wr_drop_comb",  32'(bus0.wr_drop),  32'(m_drop));
    chk("wr_drop_reg",   32'(bus1.wr_drop),  32'(m_drop));
    chk("rd_comb",       32'(bus0.rd_data),  b ? 32'd0 : 32'(m_mem[cur_a]));
    chk("rd_reg",        32'(bus1.rd_data),  32'(m_rd1));
  endtask

  task automatic model_reset();
    m_left = DEPTH;
    m_drop = 1'b0;
    m_rd1  = '0;
  endtask

  task automatic model_edge();
    logic b;
    logic acc;
    if (!rst_n) begin
      model_reset();
    end else begin
      b      = (m_left > 0);
      acc    = !b && cur_w && !cur_c;
      m_drop = cur_w && (b || cur_c);
      m_rd1  = b ? '0 : (acc ? cur_d : m_mem[cur_a]);
      if (b) begin
        m_mem[DEPTH - m_left] = '0;
        m_left--;
      end else if (cur_c) begin
        m_left = DEPTH;
      end else if (cur_w) begin
        m_mem[cur_a] = cur_d;
      end
    end
  endtask

  task automatic cycle(output logic ob, output logic od);
    @(negedge clk);
    check_outputs();
    ob = bus0.busy;
    od = bus0.clr_done;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step();
    logic ob, od;
    cycle(ob, od);
  endtask

  // Runs 20 cycles starting in the first clear cycle; optional write at cycle we_at, clr_req retried mid-clear.
  task automatic measure_clear(input int we_at, input logic [AW-1:0] we_addr);
    int nb = 0;
    int nd = 0;
    logic ob, od;
    for (int k = 0; k < 20; k++) begin
      if (k == we_at) drive(we_addr, 1'b1, DW'($urandom_range(1, 7)), 1'b0);
      else            drive(AW'($urandom), 1'b0, '0, k == 5);
      cycle(ob, od);
      if (ob) nb++;
      if (od) nd++;
    end
    chk("busy_cycles", 32'(nb), 32'd16);
    chk("clr_done_pulses", 32'(nd), 32'd1);
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) begin
      drive(AW'(i), 1'b0, '0, 1'b0);
      step();
    end
    drive('0, 1'b0, '0, 1'b0);
    step();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    model_reset();
    drive('0, 1'b0, '0, 1'b0);
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    // Power-up clear, then every address reads zero.
    measure_clear(-1, '0);
    read_all();

    // Write 7 to address 5, then read it back.
    drive(4'd5, 1'b1, 3'b111, 1'b0); step();
    drive(4'd5, 1'b0, 3'b000, 1'b0); step();
    drive(4'd0, 1'b0, 3'b000, 1'b0); step();

    // Write 4 to address 9 while reading it in the same cycle.
    drive(4'd9, 1'b1, 3'b100, 1'b0); step();
    drive(4'd9, 1'b0, 3'b000, 1'b0); step();

    // Clear with a write on cycle 3 that must be dropped.
    drive(4'd6, 1'b1, 3'b011, 1'b0); step();
    drive(4'd0, 1'b0, 3'b000, 1'b1); step();
    measure_clear(2, 4'd6);
    read_all();

    // clr_req with a simultaneous write to address 2.
    drive(4'd2, 1'b1, 3'b101, 1'b0); step();
    drive(4'd2, 1'b1, 3'b110, 1'b1); step();
    measure_clear(-1, '0);
    read_all();

    // Reset asserted in clear cycle 7 while a drop pulse is showing.
    drive(4'd3, 1'b1, 3'b111, 1'b0); step();
    drive(4'd0, 1'b0, 3'b000, 1'b1); step();
    for (int k = 0; k < 6; k++) begin
      drive(4'd4, k == 5, 3'b010, 1'b0);
      step();
    end
    chk("drop_before_reset", 32'(bus0.wr_drop), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_busy",     32'(bus0.busy),     32'd1);
    chk("rst_wr_drop",  32'(bus0.wr_drop),  32'd0);
    chk("rst_clr_done", 32'(bus1.clr_done), 32'd0);
    chk("rst_rd_comb",  32'(bus0.rd_data),  32'd0);
    chk("rst_rd_reg",   32'(bus1.rd_data),  32'd0);
    model_reset();
    drive('0, 1'b0, '0, 1'b0);
    repeat (2) step();
    rst_n = 1'b1;
    measure_clear(-1, '0);
    read_all();

    // Randomized traffic with occasional clears.
    for (int n = 0; n < 800; n++) begin
      drive(AW'($urandom), 1'($urandom), DW'($urandom), $urandom_range(0, 99) < 3);
      step();
    end
    drive('0, 1'b0, '0, 1'b0);
    repeat (17) step();
    read_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
